// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types: shot-clock state enum, BCD nibble type and a BCD validity check.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    SC_IDLE    = 2'd0,
    SC_RUN     = 2'd1,
    SC_PAUSED  = 2'd2,
    SC_EXPIRED = 2'd3
  } sc_state_t;

  typedef logic [3:0] bcdNibble_t;

  // Upper nibbles beyond the digit count must be zero so a reload cannot silently truncate.
  function automatic logic bcd_is_valid(input logic [63:0] value, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < digits && value[4*i +: 4] > 4'd9) ok = 1'b0;
      if (i >= digits && value[4*i +: 4] != 4'd0) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_dec_chain.sv
// DIGITS-wide BCD decrement-by-one with a zero flag on the result.
// Latency: combinational. Backpressure: none; a zero input wraps to all nines.
module bcd_dec_chain
  import scoreboard_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] nextValue,
  output logic                nextZero
);

  logic [DIGITS-1:0] borrow;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : gDigit
    bcdNibble_t nib;
    assign nib = value[4*i +: 4];
    assign nextValue[4*i +: 4] = !borrow[i]     ? nib :
                                 (nib == 4'd0)  ? 4'd9 : nib - 4'd1;
    if (i > 0) begin : gChain
      assign borrow[i] = borrow[i-1] && (value[4*(i-1) +: 4] == 4'd0);
    end
  end

  assign nextZero = (nextValue == '0);

endmodule

// File: rtl/shot_clock_bcd.sv
// BCD countdown shot clock with full/short reload, run/pause, prescaled tick; buzzer via SHOT_CLOCK_BUZZER_EN.
// Latency: all outputs registered, 1 cycle from sampled control to output; first decrement CLK_DIV cycles after RUN entry.
// Backpressure: none; controls are sampled every cycle with priority reload_full, reload_short, nPAUSE, start.
module shot_clock_bcd
  import scoreboard_pkg::*;
#(
  parameter int          DIGITS       = 2,
  parameter logic [63:0] RELOAD_FULL  = 64'h24,
  parameter logic [63:0] RELOAD_SHORT = 64'h14,
  parameter int          CLK_DIV      = 1,
  parameter int          BUZZ_TICKS   = 3
) (
  input  logic                CP,
  input  logic                nRST,
  input  logic                start,
  input  logic                nPAUSE,
  input  logic                reload_full,
  input  logic                reload_short,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                expired,
  output logic                expired_pulse,
  output logic                buzzer
);

  localparam logic [4*DIGITS-1:0] FULL_V  = RELOAD_FULL[4*DIGITS-1:0];
  localparam logic [4*DIGITS-1:0] SHORT_V = RELOAD_SHORT[4*DIGITS-1:0];
  localparam int                  PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]       LAST    = PW'(CLK_DIV - 1);

  if (!bcd_is_valid(RELOAD_FULL, DIGITS) || !bcd_is_valid(RELOAD_SHORT, DIGITS)) begin : gBadReload
    $error("shot_clock_bcd: reload value contains a non-BCD nibble");
  end
  if (CLK_DIV < 1 || BUZZ_TICKS < 0) begin : gBadTiming
    $error("shot_clock_bcd: CLK_DIV must be >= 1 and BUZZ_TICKS >= 0");
  end

  sc_state_t           state;
  logic [PW-1:0]       prescaler;
  logic [PW-1:0]       preNext;
  logic                tick;
  logic                reloadAny;
  logic                expireNow;
  logic [4*DIGITS-1:0] countDec;
  logic                decZero;

  bcd_dec_chain #(.DIGITS(DIGITS)) uDec (
    .value    (count),
    .nextValue(countDec),
    .nextZero (decZero)
  );

  assign tick      = (prescaler == LAST);
  assign preNext   = tick ? '0 : prescaler + 1'b1;
  assign reloadAny = reload_full || reload_short;
  // The decrement that lands on zero; reload is excluded by the priority chain in the users.
  assign expireNow = (state == SC_RUN) && nPAUSE && tick && (count != '0) && decZero;

  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      state         <= SC_IDLE;
      count         <= FULL_V;
      prescaler     <= '0;
      running       <= 1'b0;
      expired       <= 1'b0;
      expired_pulse <= 1'b0;
    end else begin
      expired_pulse <= 1'b0;
      if (reloadAny) begin
        count     <= reload_full ? FULL_V : SHORT_V;
        state     <= SC_IDLE;
        prescaler <= '0;
        running   <= 1'b0;
        expired   <= 1'b0;
      end else begin
        unique case (state)
          SC_IDLE: begin
            if (nPAUSE && start) begin
              if (count == '0) begin
                state   <= SC_EXPIRED;
                expired <= 1'b1;
              end else begin
                state   <= SC_RUN;
                running <= 1'b1;
              end
            end
          end
          SC_RUN: begin
            if (!nPAUSE) begin
              state   <= SC_PAUSED;
              running <= 1'b0;
            end else begin
              prescaler <= preNext;
              if (tick && count != '0) count <= countDec;
              if (expireNow) begin
                state         <= SC_EXPIRED;
                running       <= 1'b0;
                expired       <= 1'b1;
                expired_pulse <= 1'b1;
              end
            end
          end
          SC_PAUSED: begin
            // Prescaler is left untouched so a partial tick survives the pause.
            if (nPAUSE && start) begin
              state   <= SC_RUN;
              running <= 1'b1;
            end
          end
          SC_EXPIRED: begin
`ifdef SHOT_CLOCK_BUZZER_EN
            prescaler <= preNext;
`endif
          end
          default: state <= SC_IDLE;
        endcase
      end
    end
  end

`ifdef SHOT_CLOCK_BUZZER_EN
  localparam int BW = (BUZZ_TICKS > 0) ? $clog2(BUZZ_TICKS + 1) : 1;

  logic [BW-1:0] buzzLeft;

  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      buzzer   <= 1'b0;
      buzzLeft <= '0;
    end else if (reloadAny) begin
      buzzer   <= 1'b0;
      buzzLeft <= '0;
    end else if (expireNow) begin
      buzzer   <= (BUZZ_TICKS > 0);
      buzzLeft <= BW'(BUZZ_TICKS);
    end else if (state == SC_EXPIRED && tick && buzzer) begin
      if (buzzLeft == BW'(1)) buzzer <= 1'b0;
      buzzLeft <= buzzLeft - 1'b1;
    end
  end
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_shot_clock_bcd.sv
// Bench for shot_clock_bcd: vector table, corner-case sequences and random stimulus against a decimal reference model.
module tb_shot_clock_bcd;

  localparam int CLK_DIV    = 4;
  localparam int BUZZ_TICKS = 3;
`ifdef SHOT_CLOCK_BUZZER_EN
  localparam bit BUZZ_ON = 1'b1;
`else
  localparam bit BUZZ_ON = 1'b0;
`endif

  logic        CP = 1'b0;
  logic        nRST;
  logic        start, nPAUSE, reload_full, reload_short;
  logic [7:0]  count;
  logic        running, expired, expired_pulse, buzzer;

  logic        start2, nPAUSE2, rf2, rs2;
  logic [11:0] count2;
  logic        running2, expired2, pulse2, buzzer2;

  int checks = 0;
  int errors = 0;

  typedef enum {IdleM, RunM, PausedM, ExpiredM} mode_t;
  mode_t mMode;
  int    mCount, mPhase, mBuzz;
  bit    mPulse;

  typedef struct {
    bit         st, np, rf, rs;
    int         n;
    logic [7:0] expCount;
    bit         expRun, expExp, expPulse;
  } vec_t;
  vec_t tbl[20];

  shot_clock_bcd #(.DIGITS(2), .RELOAD_FULL(64'h24), .RELOAD_SHORT(64'h14),
                   .CLK_DIV(CLK_DIV), .BUZZ_TICKS(BUZZ_TICKS)) dut (
    .CP(CP), .nRST(nRST), .start(start), .nPAUSE(nPAUSE),
    .reload_full(reload_full), .reload_short(reload_short),
    .count(count), .running(running), .expired(expired),
    .expired_pulse(expired_pulse), .buzzer(buzzer)
  );

  shot_clock_bcd #(.DIGITS(3), .RELOAD_FULL(64'h100), .RELOAD_SHORT(64'h050),
                   .CLK_DIV(1), .BUZZ_TICKS(2)) dutBorrow (
    .CP(CP), .nRST(nRST), .start(start2), .nPAUSE(nPAUSE2),
    .reload_full(rf2), .reload_short(rs2),
    .count(count2), .running(running2), .expired(expired2),
    .expired_pulse(pulse2), .buzzer(buzzer2)
  );

  always #5 CP = ~CP;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] toBcd(input int n, input int digits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(n % 10);
        n = n / 10;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mMode = IdleM; mCount = 24; mPhase = 0; mBuzz = 0; mPulse = 0;
  endtask

  // Reference behaviour: count kept as a plain decimal integer, prescaler as a phase in 0..CLK_DIV-1.
  task automatic modelStep(input bit st, input bit np, input bit rf, input bit rs);
    bit tick;
    mPulse = 0;
    tick = (mPhase == CLK_DIV - 1);
    if (rf || rs) begin
      mCount = rf ? 24 : 14;
      mMode = IdleM; mPhase = 0; mBuzz = 0;
    end else begin
      case (mMode)
        IdleM:   if (st && np) mMode = (mCount == 0) ? ExpiredM : RunM;
        RunM: begin
          if (!np) mMode = PausedM;
          else begin
            mPhase = (mPhase + 1) % CLK_DIV;
            if (tick) begin
              mCount = mCount - 1;
              if (mCount == 0) begin
                mMode = ExpiredM; mPulse = 1;
                mBuzz = BUZZ_ON ? BUZZ_TICKS : 0;
              end
            end
          end
        end
        PausedM: if (st && np) mMode = RunM;
        ExpiredM: begin
          if (BUZZ_ON) begin
            mPhase = (mPhase + 1) % CLK_DIV;
            if (tick && mBuzz > 0) mBuzz = mBuzz - 1;
          end
        end
        default: mMode = IdleM;
      endcase
    end
  endtask

  task automatic checkModel();
    chk("model.count",   32'(count),         toBcd(mCount, 2));
    chk("model.running", 32'(running),       32'(mMode == RunM));
    chk("model.expired", 32'(expired),       32'(mMode == ExpiredM));
    chk("model.pulse",   32'(expired_pulse), 32'(mPulse));
    chk("model.buzzer",  32'(buzzer),        32'(mBuzz > 0));
  endtask

  task automatic step(input bit st, input bit np, input bit rf, input bit rs);
    start = st; nPAUSE = np; reload_full = rf; reload_short = rs;
    @(posedge CP); #1;
    modelStep(st, np, rf, rs);
    checkModel();
  endtask

  task automatic runToExpiry();
    for (int g = 0; g < 200 && mMode != ExpiredM; g++) step(0, 1, 0, 0);
    chk("wait.expired", 32'(expired), 32'd1);
  endtask

  initial begin
    bit st, np, rf, rs;
    int hiCnt, k;
    bit nibOk;

    tbl[0]  = '{0,1,0,0, 3, 8'h24, 0,0,0};
    tbl[1]  = '{1,1,0,0, 1, 8'h24, 1,0,0};
    tbl[2]  = '{0,1,0,0, 3, 8'h24, 1,0,0};
    tbl[3]  = '{0,1,0,0, 1, 8'h23, 1,0,0};
    tbl[4]  = '{0,1,0,0, 6, 8'h22, 1,0,0};
    tbl[5]  = '{0,0,0,0, 1, 8'h22, 0,0,0};
    tbl[6]  = '{0,0,0,0, 9, 8'h22, 0,0,0};
    tbl[7]  = '{1,1,0,0, 1, 8'h22, 1,0,0};
    tbl[8]  = '{0,1,0,0, 1, 8'h22, 1,0,0};
    tbl[9]  = '{0,1,0,0, 1, 8'h21, 1,0,0};
    tbl[10] = '{0,1,0,0,56, 8'h07, 1,0,0};
    tbl[11] = '{0,1,0,0, 2, 8'h07, 1,0,0};
    tbl[12] = '{0,1,0,1, 1, 8'h14, 0,0,0};
    tbl[13] = '{0,1,1,1, 1, 8'h24, 0,0,0};
    tbl[14] = '{1,0,0,0, 2, 8'h24, 0,0,0};
    tbl[15] = '{1,1,0,0, 1, 8'h24, 1,0,0};
    tbl[16] = '{0,1,0,0,96, 8'h00, 0,1,1};
    tbl[17] = '{0,1,0,0, 1, 8'h00, 0,1,0};
    tbl[18] = '{1,1,0,0, 5, 8'h00, 0,1,0};
    tbl[19] = '{0,1,0,1, 1, 8'h14, 0,0,0};

    start = 0; nPAUSE = 1; reload_full = 0; reload_short = 0;
    start2 = 0; nPAUSE2 = 1; rf2 = 0; rs2 = 0;
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    chk("reset.count",   32'(count),         32'h24);
    chk("reset.running", 32'(running),       32'd0);
    chk("reset.expired", 32'(expired),       32'd0);
    chk("reset.pulse",   32'(expired_pulse), 32'd0);
    chk("reset.buzzer",  32'(buzzer),        32'd0);
    chk("reset.count2",  32'(count2),        32'h100);
    @(posedge CP); @(posedge CP); #3;
    nRST = 1'b1;
    modelReset();

    foreach (tbl[v]) begin
      for (int c = 0; c < tbl[v].n; c++) step(tbl[v].st, tbl[v].np, tbl[v].rf, tbl[v].rs);
      chk($sformatf("vec%0d.count", v),   32'(count),         32'(tbl[v].expCount));
      chk($sformatf("vec%0d.running", v), 32'(running),       32'(tbl[v].expRun));
      chk($sformatf("vec%0d.expired", v), 32'(expired),       32'(tbl[v].expExp));
      chk($sformatf("vec%0d.pulse", v),   32'(expired_pulse), 32'(tbl[v].expPulse));
    end

    // Buzzer length when left alone.
    step(0, 1, 1, 0);
    step(1, 1, 0, 0);
    runToExpiry();
    hiCnt = buzzer ? 1 : 0;
    for (int c = 0; c < 30; c++) begin
      step(0, 1, 0, 0);
      if (buzzer) hiCnt++;
    end
    chk("buzz.length",      32'(hiCnt),   BUZZ_ON ? 32'(BUZZ_TICKS * CLK_DIV) : 32'd0);
    chk("buzz.expiredHeld", 32'(expired), 32'd1);

    // Reload aborts an active buzzer.
    step(0, 1, 1, 0);
    step(1, 1, 0, 0);
    runToExpiry();
    step(0, 1, 0, 0);
    chk("abort.buzzBefore", 32'(buzzer), 32'(BUZZ_ON));
    step(0, 1, 1, 0);
    chk("abort.buzzer",  32'(buzzer),  32'd0);
    chk("abort.expired", 32'(expired), 32'd0);
    chk("abort.count",   32'(count),   32'h24);

    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 4) == 0);
      np = ($urandom_range(0, 9) != 0);
      rf = ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(st, np, rf, rs);
    end

    // Three-digit borrow chain at one tick per cycle.
    step(0, 1, 1, 0);
    chk("borrow.init", 32'(count2), 32'h100);
    start2 = 1;
    step(0, 1, 0, 0);
    start2 = 0;
    chk("borrow.run", 32'(running2), 32'd1);
    step(0, 1, 0, 0);
    chk("borrow.099", 32'(count2), 32'h099);
    step(0, 1, 0, 0);
    chk("borrow.098", 32'(count2), 32'h098);
    for (k = 97; k >= 0; k--) begin
      step(0, 1, 0, 0);
      nibOk = 1;
      for (int d = 0; d < 3; d++) if (count2[4*d +: 4] > 4'd9) nibOk = 0;
      chk("borrow.nibbles", 32'(nibOk), 32'd1);
      chk("borrow.value", 32'(count2), toBcd(k, 3));
    end
    chk("borrow.expired", 32'(expired2), 32'd1);

    // Asynchronous reset mid-count at 11.
    step(0, 1, 1, 0);
    step(1, 1, 0, 0);
    for (int g = 0; g < 200 && mCount != 11; g++) step(0, 1, 0, 0);
    chk("arst.before", 32'(count), 32'h11);
    #1 nRST = 1'b0;
    #1;
    chk("arst.count",   32'(count),         32'h24);
    chk("arst.running", 32'(running),       32'd0);
    chk("arst.expired", 32'(expired),       32'd0);
    chk("arst.pulse",   32'(expired_pulse), 32'd0);
    chk("arst.buzzer",  32'(buzzer),        32'd0);
    chk("arst.count2",  32'(count2),        32'h100);
    #3 nRST = 1'b1;
    modelReset();
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int c = 0; c < 8; c++) step(0, 1, 0, 0);
    chk("arst.resumed", 32'(count), 32'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shot_clock_bcd.md
# shot_clock_bcd

Parametrised BCD countdown timer for the scoreboard datapath: a multi-digit shot/game clock with two selectable reload values, run/pause control, an internal tick prescaler and registered expiry flags. It sits between the system clock domain and the seven-segment display decoders, and drives the scoreboard horn logic. It generalises the fixed two-digit 24-second counter to any digit count, any reload values and any tick rate.

## Interface
- `DIGITS`, 2: number of BCD digits; count width is 4*DIGITS.
- `RELOAD_FULL`, 'h24: BCD full reload value; also the reset value.
- `RELOAD_SHORT`, 'h14: BCD short reload value (offensive-rebound reset).
- `CLK_DIV`, 1: CP cycles per count tick, ≥1; 1 means every RUN cycle is a tick.
- `BUZZ_TICKS`, 3: buzzer length in ticks. Used only with the buzzer macro.
- `CP`, in, 1: clock; rising edge.
- `nRST`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: sync; request RUN.
- `nPAUSE`, in, 1: sync, active-low; forces PAUSED from RUN.
- `reload_full`, in, 1: sync; load RELOAD_FULL.
- `reload_short`, in, 1: sync; load RELOAD_SHORT.
- `count`, out, 4*DIGITS: BCD value; digit 0 is the LSB nibble.
- `running`, out, 1: high in RUN.
- `expired`, out, 1: level; high in EXPIRED.
- `expired_pulse`, out, 1: one cycle on the RUN→EXPIRED transition.
- `buzzer`, out, 1: horn drive; see Configuration.

## Operation
- States: IDLE (loaded, stopped), RUN, PAUSED, EXPIRED. Encoding is a 2-bit enum.
- Priority within a cycle, highest first: nRST, reload_full, reload_short, nPAUSE=0, start, tick.
- A reload in any state loads the value, enters IDLE, clears the prescaler, clears expired and buzzer, and suppresses that cycle's tick. If both reloads are asserted, full wins.
- IDLE: start with nPAUSE=1 → RUN. If count is already 0, start → EXPIRED and no pulse is generated.
- RUN: nPAUSE=0 → PAUSED, with no decrement that cycle. A tick with count ≠ 0 decrements; if the result is 0 → EXPIRED with expired_pulse.
- PAUSED: the prescaler value is held, so fractional ticks are preserved. start with nPAUSE=1 → RUN.
- EXPIRED: count holds at 0 and start is ignored. Only a reload (or reset) exits.
- Decrement: BCD borrow chain across DIGITS. A nibble of 0 becomes 9 and borrows from the next nibble. Binary values never appear.
- Reload parameters containing a nibble >9 are a configuration error, flagged by a simulation-only elaboration check.

## Timing
- Reset values: count=RELOAD_FULL, state IDLE, running=0, expired=0, expired_pulse=0, buzzer=0, prescaler=0.
- All outputs are registered; there is no combinational input→output path.
- The prescaler advances only in RUN. A tick occurs in the cycle where the prescaler equals CLK_DIV-1; the prescaler then wraps to 0.
- The count updates on the CP edge ending the tick cycle. With CLK_DIV=N, the first decrement is N cycles after the RUN entry edge.
- Latency from start or nPAUSE sampled to running changing is 1 cycle.
- expired and expired_pulse rise on the same edge that count becomes 0.
- Reset mid-RUN clears immediately and asynchronously. The release of reset is synchronised externally.

## Configuration
- `SHOT_CLOCK_BUZZER_EN` defined:
  - buzzer rises with expired_pulse.
  - The prescaler keeps running in EXPIRED to time the buzzer.
  - buzzer stays high for BUZZ_TICKS ticks, then drops; expired stays high.
  - A reload aborts the buzzer in the same cycle.
- `SHOT_CLOCK_BUZZER_EN` undefined:
  - buzzer is tied 0 and the BUZZ_TICKS logic is absent.
  - The prescaler halts in EXPIRED.

## Structure
- Package `scoreboard_pkg`:
  - state enum `sc_state_t`.
  - BCD nibble type.
  - function `bcd_is_valid`.
- Sub-module `bcd_dec_chain`: combinational DIGITS-wide BCD decrement. It returns the next value and a zero flag, and is reusable by the game clock.
- The prescaler and FSM stay inline.

## Test plan
- Reset, then start, with CLK_DIV=4: count 24→23 exactly 4 cycles after RUN entry; reaches 00 after 96 tick cycles with expired_pulse for one cycle; count holds at 00.
- Borrow, with DIGITS=3, RELOAD_FULL='h100: count goes 100→099→098, and no nibble ever exceeds 9.
- Pause at prescaler value 2, hold for 10 cycles, resume: the next decrement occurs 2 cycles after resume and count is unchanged while paused.
- reload_short in mid-RUN at count 07 → count=14, state IDLE, running=0. reload_full and reload_short together → count=24.
- Reload while EXPIRED with the buzzer active (macro on, BUZZ_TICKS=3, CLK_DIV=2): buzzer high for 6 cycles when left alone. A reload in cycle 2 drops buzzer and expired on the next edge.
- nRST asserted mid-count at 11: count=24 and all flags 0 asynchronously, before the next CP edge.
